mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-ported word memory (`mem_system`) between two requesters: the fetch stage (read-only) and the memory stage (read/write).
- Serialises requests and holds each memory command until the memory signals completion, so it supports both the current single-cycle memory and the planned variable-latency memory.
- Data port has priority; a streak limit prevents fetch starvation. A timeout guards against a hung memory.

Parameters:
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits before fetch is forced through (1..15)
- TIMEOUT, 64, cycles in BUSY without mem_valid before the op is aborted with error (2..255)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch read request; held with i_addr stable until i_ack
- i_addr  in  32  fetch byte address
- i_ack  out  1  one-cycle pulse: fetch op complete
- i_rdata  out  32  fetch read data, valid with i_ack
- i_err  out  1  timeout flag, valid with i_ack
- d_req  in  1  data request; held with d_wr/d_addr/d_wdata stable until d_ack
- d_wr  in  1  1=write, 0=read
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_ack  out  1  one-cycle pulse: data op complete
- d_rdata  out  32  data read data, valid with d_ack (0 for writes)
- d_err  out  1  timeout flag, valid with d_ack
- mem_rd  out  1  memory read command, held for whole op
- mem_wr  out  1  memory write command, held for whole op
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data, sampled with mem_valid
- mem_valid  in  1  memory op complete (reads and writes)
- busy  out  1  high in BUSY_I/BUSY_D

Behaviour:
- Reset:
  - State IDLE; all outputs 0; streak and timeout counters 0.
  - A reset mid-op abandons the outstanding op; no ack is issued for it.
- States:
  - IDLE: no command driven.
  - BUSY_I: fetch op in progress.
  - BUSY_D: data op in progress.
- Grant (IDLE, cycle N):
  - If d_req and not (i_req and streak==MAX_D_STREAK): go to BUSY_D.
  - Else if i_req: go to BUSY_I.
- Command registration:
  - mem_rd/mem_wr/mem_addr/mem_wdata are registered at the N->N+1 edge.
  - They stay constant through BUSY.
  - Exactly one of mem_rd/mem_wr is high while busy.
- Completion:
  - mem_valid sampled high in BUSY at cycle M.
  - At M+1: x_ack=1, x_rdata=mem_rdata (reads) or 0 (writes), x_err=0, mem_rd=mem_wr=0, state IDLE.
  - Minimum request-to-ack latency is 2 cycles (mem_valid in first BUSY cycle).
  - ack, rdata and err are all 0 except in the ack cycle.
- Ack-cycle masking:
  - In the IDLE cycle where x_ack=1, x_req is masked from arbitration.
  - The other port may be granted in that cycle.
  - The acked port's new request is seen no earlier than the following cycle.
- Streak counter (4-bit):
  - On a data grant with i_req high: increment, saturating at MAX_D_STREAK.
  - On a data grant with i_req low: clear to 0.
  - On a fetch grant: clear to 0.
- Timeout:
  - The counter clears on entry to BUSY and increments every BUSY cycle without mem_valid.
  - When it reaches TIMEOUT-1 without mem_valid, the next edge issues ack with err=1 and rdata=0, drops the command, and returns to IDLE.
  - mem_valid arriving in IDLE is ignored.
- mem_valid in the same cycle as timeout expiry: normal completion wins (err=0).
- Requester fields changing before ack: undefined; not checked.

Test Plan:
- Single fetch:
  - Stimulus: i_req, i_addr=0x2007; mem returns mem_valid in the first BUSY cycle with mem_rdata=0xDEADBEEF.
  - Response: mem_addr=0x2004, mem_rd=1 for 1 cycle; i_ack 2 cycles after req with i_rdata=0xDEADBEEF, i_err=0.
- Data write with 3-cycle memory:
  - Stimulus: d_req, d_wr=1, d_addr=0x2010, d_wdata=0x12345678; mem_valid on the 3rd BUSY cycle.
  - Response: mem_wr held 3 cycles with stable addr/data; d_ack with d_rdata=0.
- Simultaneous requests:
  - Stimulus: i_req and d_req raised together, 1-cycle memory.
  - Response: data granted first; fetch granted in the d_ack cycle; i_ack 2 cycles after d_ack.
- Starvation:
  - Stimulus: i_req held, d_req reasserted continuously, MAX_D_STREAK=4.
  - Response: exactly 4 data ops, then 1 fetch op, then the data sequence repeats.
- Timeout:
  - Stimulus: TIMEOUT=8, mem_valid never asserted on a data read.
  - Response: d_ack with d_err=1, d_rdata=0 after 8 BUSY cycles; mem_rd drops; a later stray mem_valid produces no ack.
- Reset mid-op:
  - Stimulus: rst pulsed during BUSY_I.
  - Response: next cycle all outputs 0 and state IDLE; no i_ack; a subsequent request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one word memory between fetch (read-only) and data (read/write) requesters.
// Latency: command registered the edge after grant; ack registered the edge after mem_valid (min 2 cycles req->ack).
// Backpressure: requesters hold until their one-cycle ack; the command is held until mem_valid or timeout.
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  to_q, to_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        i_ack_q, i_ack_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        i_err_q, i_err_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;

  // A port is ignored in the cycle its previous op is acked, so a request
  // still high there is the requester's next op, seen one cycle later.
  logic i_req_arb;
  logic d_req_arb;
  assign i_req_arb = i_req & ~i_ack_q;
  assign d_req_arb = d_req & ~d_ack_q;

  // Memory ignores the byte offset; only word addresses are issued.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  // Arbitration, command capture, completion and timeout handling.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    to_d        = to_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    i_rdata_d   = '0;
    i_err_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_rdata_d   = '0;
    d_err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Data wins unless fetch has already waited through a full streak.
        if (d_req_arb && !(i_req_arb && (streak_q == STREAK_MAX))) begin
          state_d     = BUSY_D;
          mem_rd_d    = ~d_wr;
          mem_wr_d    = d_wr;
          mem_addr_d  = {d_addr[31:2], 2'b00};
          mem_wdata_d = d_wr ? d_wdata : '0;
          to_d        = '0;
          if (i_req) begin
            streak_d = (streak_q < STREAK_MAX) ? streak_q + 4'd1 : streak_q;
          end else begin
            streak_d = '0;
          end
        end else if (i_req_arb) begin
          state_d     = BUSY_I;
          mem_rd_d    = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = {i_addr[31:2], 2'b00};
          mem_wdata_d = '0;
          to_d        = '0;
          streak_d    = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        // Normal completion takes precedence over a timeout in the same cycle.
        if (mem_valid || (to_q == TO_LAST)) begin
          state_d     = IDLE;
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = (mem_valid && mem_rd_q) ? mem_rdata : '0;
            i_err_d   = ~mem_valid;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = (mem_valid && mem_rd_q) ? mem_rdata : '0;
            d_err_d   = ~mem_valid;
          end
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, held memory command and registered acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      to_q        <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      i_err_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      to_q        <= to_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      i_rdata_q   <= i_rdata_d;
      i_err_q     <= i_err_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign i_err     = i_err_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus multi-cycle sequences
// for timeout, timeout/valid collision, reset mid-op and fetch starvation.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .busy(busy)
  );

  typedef struct packed {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_valid;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
  } out_t;

  typedef struct packed {
    in_t  vi;
    out_t vo;
  } vec_t;

  int checks = 0;
  int errors = 0;

  vec_t        tbl [17];
  int          n;
  int          rd_cnt;
  int          acks;
  int          nack;
  bit          got;
  logic        ack_err;
  logic        ack_rd;
  logic [31:0] ack_rdata;
  logic [31:0] addr_seen;
  logic [9:0]  seq;

  function automatic in_t mi(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                             input logic [31:0] da, input logic [31:0] dwd, input logic mv,
                             input logic [31:0] mr);
    in_t v;
    v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_wr = dw; v.d_addr = da; v.d_wdata = dwd;
    v.mem_valid = mv; v.mem_rdata = mr;
    return v;
  endfunction

  function automatic out_t mo(input logic ia, input logic [31:0] ird, input logic ie,
                              input logic da, input logic [31:0] drd, input logic de,
                              input logic mr, input logic mw, input logic [31:0] ma,
                              input logic [31:0] mwd, input logic b);
    out_t v;
    v.i_ack = ia; v.i_rdata = ird; v.i_err = ie; v.d_ack = da; v.d_rdata = drd; v.d_err = de;
    v.mem_rd = mr; v.mem_wr = mw; v.mem_addr = ma; v.mem_wdata = mwd; v.busy = b;
    return v;
  endfunction

  function automatic out_t cur();
    return mo(i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, mem_rd, mem_wr, mem_addr, mem_wdata, busy);
  endfunction

  task automatic apply(input in_t v);
    i_req = v.i_req; i_addr = v.i_addr; d_req = v.d_req; d_wr = v.d_wr; d_addr = v.d_addr;
    d_wdata = v.d_wdata; mem_valid = v.mem_valid; mem_rdata = v.mem_rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    // Single fetch, 1-cycle memory
    tbl[0]  = '{mi(1, 32'h2007, 0, 0, 0, 0, 0, 0),                      mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{mi(1, 32'h2007, 0, 0, 0, 0, 1, 32'hDEADBEEF),          mo(0, 0, 0, 0, 0, 0, 1, 0, 32'h2004, 0, 1)};
    tbl[2]  = '{mi(0, 0, 0, 0, 0, 0, 0, 0),                             mo(1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    // Data write, 3-cycle memory; rdata on the bus must not leak into a write ack
    tbl[3]  = '{mi(0, 0, 1, 1, 32'h2010, 32'h12345678, 0, 0),          mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{mi(0, 0, 1, 1, 32'h2010, 32'h12345678, 0, 0),          mo(0, 0, 0, 0, 0, 0, 0, 1, 32'h2010, 32'h12345678, 1)};
    tbl[5]  = '{mi(0, 0, 1, 1, 32'h2010, 32'h12345678, 0, 0),          mo(0, 0, 0, 0, 0, 0, 0, 1, 32'h2010, 32'h12345678, 1)};
    tbl[6]  = '{mi(0, 0, 1, 1, 32'h2010, 32'h12345678, 1, 32'hFFFFFFFF), mo(0, 0, 0, 0, 0, 0, 0, 1, 32'h2010, 32'h12345678, 1)};
    tbl[7]  = '{mi(0, 0, 0, 0, 0, 0, 0, 0),                             mo(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)};
    // Simultaneous requests: data first, fetch in d_ack cycle despite d_req still high
    tbl[8]  = '{mi(1, 32'h100, 1, 0, 32'h203, 0, 0, 0),                mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{mi(1, 32'h100, 1, 0, 32'h203, 0, 1, 32'hAAAA5555),     mo(0, 0, 0, 0, 0, 0, 1, 0, 32'h200, 0, 1)};
    tbl[10] = '{mi(1, 32'h100, 1, 0, 32'h203, 0, 0, 0),                mo(0, 0, 0, 1, 32'hAAAA5555, 0, 0, 0, 0, 0, 0)};
    tbl[11] = '{mi(1, 32'h100, 1, 0, 32'h203, 0, 1, 32'h11112222),     mo(0, 0, 0, 0, 0, 0, 1, 0, 32'h100, 0, 1)};
    tbl[12] = '{mi(0, 0, 1, 0, 32'h203, 0, 0, 0),                      mo(1, 32'h11112222, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[13] = '{mi(0, 0, 1, 0, 32'h203, 0, 1, 32'h33334444),           mo(0, 0, 0, 0, 0, 0, 1, 0, 32'h200, 0, 1)};
    tbl[14] = '{mi(0, 0, 0, 0, 0, 0, 0, 0),                             mo(0, 0, 0, 1, 32'h33334444, 0, 0, 0, 0, 0, 0)};
    // Stray mem_valid in IDLE is ignored
    tbl[15] = '{mi(0, 0, 0, 0, 0, 0, 1, 32'hCAFE0000),                 mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[16] = '{mi(0, 0, 0, 0, 0, 0, 0, 0),                             mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

    rst = 1'b1;
    apply(mi(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    tick();
    rst = 1'b0;

    for (int k = 0; k < 17; k++) begin
      apply(tbl[k].vi);
      chk_out($sformatf("row%0d", k), cur(), tbl[k].vo);
      tick();
    end

    // Timeout: read with no mem_valid; ack after 8 BUSY cycles
    apply(mi(0, 0, 1, 0, 32'h304, 0, 0, 0));
    rd_cnt = 0; got = 0; n = 0; ack_err = 0; ack_rd = 1; ack_rdata = 32'hFFFFFFFF;
    while (!got && n < 30) begin
      tick();
      n++;
      if (mem_rd) rd_cnt++;
      if (d_ack) begin
        got = 1; ack_err = d_err; ack_rdata = d_rdata; ack_rd = mem_rd;
        d_req = 0;
      end
    end
    chk("to_ack_seen", 32'(got), 1);
    chk("to_latency", n, 9);
    chk("to_rd_cycles", rd_cnt, 8);
    chk("to_err", 32'(ack_err), 1);
    chk("to_rdata", ack_rdata, 0);
    chk("to_mem_rd_drop", 32'(ack_rd), 0);

    mem_valid = 1; mem_rdata = 32'h0BAD0BAD;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (i_ack || d_ack || busy) acks++;
      if (k == 1) mem_valid = 0;
    end
    chk("stray_no_ack", acks, 0);

    // mem_valid in the very cycle the timeout would expire: normal completion
    apply(mi(0, 0, 1, 0, 32'h308, 0, 0, 32'h5A5A5A5A));
    rd_cnt = 0; got = 0; n = 0; ack_err = 1; ack_rdata = 0;
    while (!got && n < 30) begin
      tick();
      n++;
      if (d_ack) begin
        got = 1; ack_err = d_err; ack_rdata = d_rdata;
        d_req = 0; mem_valid = 0;
      end else begin
        if (mem_rd) rd_cnt++;
        mem_valid = (rd_cnt == 8);
      end
    end
    chk("coll_latency", n, 9);
    chk("coll_err", 32'(ack_err), 0);
    chk("coll_rdata", ack_rdata, 32'h5A5A5A5A);
    tick();

    // Reset during BUSY_I abandons the op
    apply(mi(1, 32'h400, 0, 0, 0, 0, 0, 0));
    tick();
    tick();
    chk("rst_busy_before", 32'(busy), 1);
    rst = 1; i_req = 0;
    tick();
    rst = 0;
    chk_out("rst_outputs_zero", cur(), mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (i_ack || busy) acks++;
    end
    chk("rst_no_ack", acks, 0);

    apply(mi(1, 32'h404, 0, 0, 0, 0, 0, 32'h77778888));
    got = 0; n = 0; ack_rdata = 0; addr_seen = 0;
    while (!got && n < 30) begin
      tick();
      n++;
      if (i_ack) begin
        got = 1; ack_rdata = i_rdata;
        i_req = 0; mem_valid = 0;
      end else begin
        if (mem_rd) addr_seen = mem_addr;
        mem_valid = mem_rd;
      end
    end
    chk("rst_recover_latency", n, 2);
    chk("rst_recover_rdata", ack_rdata, 32'h77778888);
    chk("rst_recover_addr", addr_seen, 32'h404);
    tick();
    tick();

    // Starvation: fetch withdraws only in d_ack cycles; 4 data ops then 1 fetch, repeating
    apply(mi(1, 32'h500, 1, 0, 32'h600, 0, 0, 32'h0));
    seq = '0; nack = 0; n = 0;
    while (nack < 10 && n < 100) begin
      tick();
      n++;
      if (d_ack || i_ack) begin
        seq[nack] = i_ack;
        nack++;
      end
      mem_valid = mem_rd | mem_wr;
      i_req = ~d_ack;
    end
    i_req = 0; d_req = 0; mem_valid = 0;
    chk("starve_ack_count", nack, 10);
    chk("starve_order", 32'(seq), 32'(10'b1000010000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
